dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//   Shares the single-port synchronous data memory (matrix operand/result store)
//   between the pipelined CPU MEM stage and a host/debug port.
//   - The host port loads matrices before a run and reads results afterwards.
//   - Conflicts go to the CPU, with a starvation bound for the host.
//   - host_lock gives the host exclusive ownership and stalls the CPU.
//   - Read data is routed back to whichever requester was granted.
// PARAMETERS
//   DATA_WIDTH    32  memory word width
//   ADDR_WIDTH    10  word address width (covers M*N+N*N2+M*N2 = 300 words)
//   STARVE_LIMIT  8   consecutive refused host cycles before host wins a conflict (1..255)
// PORTS
//   CLOCK_50     in   1   system clock, all state on rising edge
//   rst          in   1   synchronous reset, active-high
//   cpu_req      in   1   CPU MEM-stage access request
//   cpu_we       in   1   1 = store, 0 = load
//   cpu_addr     in   AW  word address
//   cpu_wdata    in   DW  store data
//   cpu_stall    out  1   cpu_req refused this cycle; pipeline must hold
//   cpu_rdata    out  DW  load data (= mem_rdata)
//   cpu_rvalid   out  1   cpu_rdata valid for load granted previous cycle
//   host_lock    in   1   request exclusive host ownership
//   host_locked  out  1   FSM in LOCKED state
//   host_req     in   1   host access request
//   host_we      in   1   1 = write, 0 = read
//   host_addr    in   AW  word address
//   host_wdata   in   DW  write data
//   host_gnt     out  1   host access accepted this cycle
//   host_rdata   out  DW  read data (= mem_rdata)
//   host_rvalid  out  1   host_rdata valid for read granted previous cycle
//   mem_en       out  1   memory access this cycle
//   mem_we       out  1   memory write enable
//   mem_addr     out  AW  memory address
//   mem_wdata    out  DW  memory write data
//   mem_rdata    in   DW  memory read data, registered, 1-cycle latency
// BEHAVIOUR
//   Reset: state=RUN, starve_cnt=0, rd_pending=0, rd_owner=CPU.
//     cpu_rvalid=host_rvalid=host_locked=0.
//     While rst=1, combinational outputs are forced: host_gnt=0, mem_en=0, cpu_stall=0.
//   Grants are combinational from inputs plus registered state.
//     mem_* is a mux of the granted requester; all zero when nothing is granted.
//   RUN arbitration:
//     - Only one requester: it is granted.
//     - Both request: CPU is granted unless starve_cnt==STARVE_LIMIT; then host is granted.
//   starve_cnt (RUN only):
//     - +1 each cycle host_req=1 and host_gnt=0, saturating at STARVE_LIMIT.
//     - Cleared on any host grant and on entry to LOCKED.
//   cpu_stall = cpu_req & ~cpu_granted, in all states.
//   LOCKED: host granted whenever host_req=1; CPU never granted.
//   FSM transitions:
//     - RUN->LOCKED at the edge where host_lock=1. That cycle still arbitrates as RUN.
//     - LOCKED->RUN at the edge where host_lock=0.
//     - host_locked is high during LOCKED.
//   Reads:
//     - A granted read (mem_we=0) sets rd_pending=1 and rd_owner=winner at the edge.
//     - Next cycle: cpu_rvalid or host_rvalid = rd_pending & owner match.
//     - rd_pending is rewritten every cycle (1 only if a read was granted).
//     - A read granted in the last RUN cycle returns correctly in the first LOCKED cycle.
//   Writes: commit at the edge of the grant cycle; no response pulse.
//   Read-after-write to the same address in consecutive cycles returns the new data.
//     This is a memory property; the arbiter adds no bypass.
//   Reset mid-operation: a pending read is discarded and no rvalid pulses afterwards.
//     A lock in progress is dropped (state returns to RUN).
// TESTING
//   1. CPU-only load, addr 5 holding 0x0000_00AB -> cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0xAB.
//   2. Host write 0x1234 @7, then host read @7 -> host_gnt=1 both cycles; host_rvalid=1 with 0x1234.
//   3. cpu_req and host_req held high 20 cycles, STARVE_LIMIT=8 -> host granted on cycles 9 and 18;
//      cpu_stall=1 exactly those cycles.
//   4. CPU load granted in the same cycle host_lock rises -> cpu_rvalid=1 next cycle, host_locked=1.
//      cpu_stall=1 while LOCKED; CPU resumes the cycle after host_lock falls.
//   5. Host read granted, rst=1 next cycle -> host_rvalid stays 0; all outputs at reset values.
//   6. Neither requests -> mem_en=0, both rvalids 0 the following cycle; starve_cnt unchanged.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one single-port synchronous RAM between the
// CPU MEM stage and a host/debug port. The CPU wins conflicts, but a host that
// has been refused STARVE_LIMIT consecutive cycles wins the next conflict.
// host_lock hands the memory exclusively to the host and stalls the CPU.
module dmem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    input  logic                  host_lock,
    output logic                  host_locked,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic       OWNER_CPU  = 1'b0;
    localparam logic       OWNER_HOST = 1'b1;

    state_e     state_q, state_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       rd_pending_q, rd_pending_d;
    logic       rd_owner_q, rd_owner_d;

    logic       cpu_gnt_s;
    logic       host_gnt_s;

    // Grant decision: nothing while in reset, host-only while locked, CPU-first otherwise.
    always_comb begin
        cpu_gnt_s  = 1'b0;
        host_gnt_s = 1'b0;
        if (rst) begin
            cpu_gnt_s  = 1'b0;
            host_gnt_s = 1'b0;
        end else if (state_q == ST_LOCKED) begin
            host_gnt_s = host_req;
        end else if (cpu_req && host_req) begin
            if (starve_cnt_q == STARVE_MAX) begin
                host_gnt_s = 1'b1;
            end else begin
                cpu_gnt_s = 1'b1;
            end
        end else begin
            cpu_gnt_s  = cpu_req;
            host_gnt_s = host_req;
        end
    end

    // Memory-side mux: route the granted requester, all zero when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // Next-state: lock FSM, host starvation counter and read-return tracking.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        rd_pending_d = (cpu_gnt_s || host_gnt_s) && !mem_we;
        rd_owner_d   = rd_owner_q;
        if (host_gnt_s) begin
            rd_owner_d = OWNER_HOST;
        end else if (cpu_gnt_s) begin
            rd_owner_d = OWNER_CPU;
        end else begin
            rd_owner_d = rd_owner_q;
        end
        case (state_q)
            ST_RUN: begin
                if (host_lock) begin
                    state_d      = ST_LOCKED;
                    starve_cnt_d = 8'd0;
                end else if (host_gnt_s) begin
                    starve_cnt_d = 8'd0;
                end else if (host_req && (starve_cnt_q != STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + 8'd1;
                end else begin
                    starve_cnt_d = starve_cnt_q;
                end
            end
            ST_LOCKED: begin
                if (!host_lock) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d      = ST_RUN;
                starve_cnt_d = 8'd0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q      <= ST_RUN;
            starve_cnt_q <= 8'd0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= OWNER_CPU;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Requester-side outputs; reset masks any pending return and the lock flag.
    assign cpu_stall   = cpu_req && !cpu_gnt_s && !rst;
    assign host_gnt    = host_gnt_s;
    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;
    assign cpu_rvalid  = rd_pending_q && (rd_owner_q == OWNER_CPU) && !rst;
    assign host_rvalid = rd_pending_q && (rd_owner_q == OWNER_HOST) && !rst;
    assign host_locked = (state_q == ST_LOCKED) && !rst;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_dmem_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int LIMIT = 8;

    logic          CLOCK_50;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          host_lock, host_locked;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    dmem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .host_lock(host_lock), .host_locked(host_locked),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 5) return 32'h0000_00AB;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural single-port RAM with registered 1-cycle read data.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          init_mem;
    always @(posedge CLOCK_50) begin
        if (init_mem) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model state (transaction level).
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_locked;
    int            m_starve;
    bit            m_pend;
    bit            m_pend_host;
    logic [DW-1:0] m_pend_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs against the model, advance the model.
    task automatic step(input logic r,
                        input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic hl,
                        input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        bit            cg, hg, any_g, g_we;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_data;
        @(negedge CLOCK_50);
        rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_lock = hl; host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        #1;
        cg = 1'b0; hg = 1'b0;
        if (!r) begin
            if (m_locked)        hg = hr;
            else if (cr && hr)   begin hg = (m_starve == LIMIT); cg = !hg; end
            else                 begin cg = cr; hg = hr; end
        end
        any_g  = cg || hg;
        g_we   = cg ? cw : (hg ? hw : 1'b0);
        g_addr = cg ? ca : (hg ? ha : '0);
        g_data = cg ? cd : (hg ? hd : '0);

        check("host_gnt",  64'(host_gnt),  64'(hg));
        check("cpu_stall", 64'(cpu_stall), 64'(!r && cr && !cg));
        check("mem_en",    64'(mem_en),    64'(any_g));
        check("mem_we",    64'(mem_we),    64'(g_we));
        check("mem_addr",  64'(mem_addr),  64'(g_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(g_data));
        check("cpu_rvalid",  64'(cpu_rvalid),  64'(!r && m_pend && !m_pend_host));
        check("host_rvalid", 64'(host_rvalid), 64'(!r && m_pend && m_pend_host));
        check("host_locked", 64'(host_locked), 64'(!r && m_locked));
        if (!r && m_pend && !m_pend_host) check("cpu_rdata",  64'(cpu_rdata),  64'(m_pend_data));
        if (!r && m_pend &&  m_pend_host) check("host_rdata", 64'(host_rdata), 64'(m_pend_data));

        if (r) begin
            m_locked = 1'b0; m_starve = 0; m_pend = 1'b0; m_pend_host = 1'b0;
        end else begin
            if (!m_locked) begin
                if (hl || hg)  m_starve = 0;
                else if (hr)   m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            end
            m_pend = any_g && !g_we;
            if (any_g) m_pend_host = hg;
            if (any_g && !g_we) m_pend_data = ref_mem[g_addr];
            if (any_g && g_we)  ref_mem[g_addr] = g_data;
            m_locked = hl;
        end
    endtask

    task automatic idle(input logic r, input logic hl);
        step(r, 1'b0, 1'b0, '0, '0, hl, 1'b0, 1'b0, '0, '0);
    endtask

    bit          lock_s;
    logic [AW-1:0] ra, rb;

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_lock = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
        m_locked = 1'b0; m_starve = 0; m_pend = 1'b0; m_pend_host = 1'b0; m_pend_data = '0;
        init_mem = 1'b1;
        idle(1'b1, 1'b0);
        init_mem = 1'b0;
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // CPU-only load of address 5.
        step(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        check("t1_stall", 64'(cpu_stall), 64'd0);
        idle(1'b0, 1'b0);
        check("t1_rvalid", 64'(cpu_rvalid), 64'd1);
        check("t1_rdata",  64'(cpu_rdata),  64'h0000_00AB);

        // Host write then read-back at address 7.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 10'd7, 32'h0000_1234);
        check("t2_gnt_w", 64'(host_gnt), 64'd1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 10'd7, '0);
        check("t2_gnt_r", 64'(host_gnt), 64'd1);
        idle(1'b0, 1'b0);
        check("t2_rvalid", 64'(host_rvalid), 64'd1);
        check("t2_rdata",  64'(host_rdata),  64'h0000_1234);

        // Sustained conflict: host breaks through on cycles 9 and 18.
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 1'b0, 10'(k), '0, 1'b0, 1'b1, 1'b0, 10'(k + 100), '0);
            check("t3_host_gnt", 64'(host_gnt),  64'((k == 9) || (k == 18)));
            check("t3_cpu_stall", 64'(cpu_stall), 64'((k == 9) || (k == 18)));
        end
        idle(1'b1, 1'b0);

        // CPU load in the cycle host_lock rises, then a locked stretch.
        step(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        check("t4_gnt", 64'(cpu_stall), 64'd0);
        step(1'b0, 1'b1, 1'b0, 10'd6, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        check("t4_rvalid", 64'(cpu_rvalid),  64'd1);
        check("t4_rdata",  64'(cpu_rdata),   64'h0000_00AB);
        check("t4_locked", 64'(host_locked), 64'd1);
        check("t4_stall",  64'(cpu_stall),   64'd1);
        step(1'b0, 1'b1, 1'b0, 10'd6, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        check("t4_stall_fall", 64'(cpu_stall), 64'd1);
        step(1'b0, 1'b1, 1'b0, 10'd6, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        check("t4_resume", 64'(cpu_stall), 64'd0);

        // Reset immediately after a granted host read.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 10'd7, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        check("t5_rvalid_rst", 64'(host_rvalid), 64'd0);
        check("t5_locked_rst", 64'(host_locked), 64'd0);
        idle(1'b0, 1'b0);
        check("t5_rvalid_after", 64'(host_rvalid), 64'd0);
        check("t5_locked_after", 64'(host_locked), 64'd0);

        // Idle cycle: no access, no responses.
        idle(1'b0, 1'b0);
        check("t6_mem_en", 64'(mem_en), 64'd0);
        idle(1'b0, 1'b0);
        check("t6_cpu_rvalid",  64'(cpu_rvalid),  64'd0);
        check("t6_host_rvalid", 64'(host_rvalid), 64'd0);

        // Randomized traffic over a small address window to exercise read-after-write.
        lock_s = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 24) == 0) lock_s = !lock_s;
            ra = 10'($urandom_range(0, 15));
            rb = 10'($urandom_range(0, 15));
            step(($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, DW'($urandom),
                 lock_s,
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rb, DW'($urandom));
        end
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
